// File: rtl/motor_controller_core_pkg.sv
// Shared definitions for the motor controller core peripherals.
//   ADDR_*  : word offsets of the sysbutton register map
//   EDGE_*  : edge-capture selection codes
//   edge_hit: qualifies one bit's stable-level transition against an edge selection
package motor_controller_core_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // True when the transition prev->cur matches the requested edge type.
  function automatic logic edge_hit(input int unsigned edge_type, input logic cur,
                                    input logic prev);
    case (edge_type)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      EDGE_ANY:  return cur ^ prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/motor_controller_core_sysbutton_debounce.sv
// One-bit input conditioner: 2-flop synchroniser followed by a hold-time debouncer.
//   clk, reset_n : clock, async active-low reset
//   i_pin        : raw asynchronous pin
//   o_stable     : debounced level (changes only after DEBOUNCE_CYCLES of a new level)
module motor_controller_core_sysbutton_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  // Count while the synchronised level differs; accept on the last count, drop the
  // count whenever the level returns to the accepted value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/motor_controller_core_sysbutton.sv
// Avalon-MM button/limit-switch input port with edge capture and maskable interrupt.
//   clk, reset_n          : clock, async active-low reset
//   address, chipselect,
//   read_n, write_n,
//   writedata, readdata   : Avalon-MM slave, zero wait states, read latency 1
//   in_port[WIDTH-1:0]    : raw asynchronous pins
//   irq                   : level interrupt, |(edgecapture & irqmask), registered
module motor_controller_core_sysbutton
  import motor_controller_core_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0]  w_stable;
  logic [WIDTH-1:0]  w_edge;
  logic [WIDTH-1:0]  w_clr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_wr;
  logic              w_rd;
  logic              w_unused_wdata;

  logic [WIDTH-1:0]  r_stable_d;
  logic [WIDTH-1:0]  r_edgecap;
  logic [WIDTH-1:0]  r_irqmask;
  logic [DATA_W-1:0] r_readdata;
  logic              r_irq;

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & ~read_n;
  // Only the low WIDTH bits of writedata carry register content.
  assign w_unused_wdata = ^writedata;

  // Per-pin synchroniser + debouncer.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    motor_controller_core_sysbutton_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_pin   (in_port[g]),
      .o_stable(w_stable[g])
    );
  end

  // Qualifying edges of the debounced levels.
  always_comb begin
    w_edge = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_edge[i] = edge_hit(EDGE_TYPE, w_stable[i], r_stable_d[i]);
    end
  end

  assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Edge capture (new edge wins over a same-cycle clear), mask and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '0;
      r_edgecap  <= '0;
      r_irqmask  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && (address == ADDR_IRQMASK)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  // Read mux; unused upper bits and the reserved offset read as zero.
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:    w_rdata = DATA_W'(w_stable);
      ADDR_IRQMASK: w_rdata = DATA_W'(r_irqmask);
      ADDR_EDGECAP: w_rdata = DATA_W'(r_edgecap);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
